// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Optional lock-loss glitch filter: PLL_LOCK_GLITCH_FILTER_EN.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int unsigned RETRY_W           = 8;
    localparam int unsigned LOSS_W            = 8;
    localparam int unsigned GLITCH_FILTER_LEN = 4;

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings.
// master = sequencer side, slave = board/CCC/fabric side.
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic                 ENABLE;
    logic                 PLL_LOCK_0;
    logic                 PLL_POWERDOWN_N_0;
    logic                 FAB_RESET_N;
    logic                 READY;
    logic                 FAULT;
    logic [RETRY_W-1:0]   RETRY_CNT;
    logic [LOSS_W-1:0]    LOCK_LOSS_CNT;
    logic [2:0]           STATE;

    modport master (
        input  ENABLE, PLL_LOCK_0,
        output PLL_POWERDOWN_N_0, FAB_RESET_N, READY, FAULT,
               RETRY_CNT, LOCK_LOSS_CNT, STATE
    );

    modport slave (
        output ENABLE, PLL_LOCK_0,
        input  PLL_POWERDOWN_N_0, FAB_RESET_N, READY, FAULT,
               RETRY_CNT, LOCK_LOSS_CNT, STATE
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / lock-qualification sequencer clocked from the free-running reference.
// Define PLL_LOCK_GLITCH_FILTER_EN to ignore lock drops shorter than GLITCH_FILTER_LEN cycles in RUN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PWRDN_CYCLES       = 64,
    parameter int unsigned LOCK_TIMEOUT       = 20000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                 REF_CLK_0,
    input  logic                 RESET_0,
    pll_lock_sequencer_if.master bus
);

    localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
        $error("CNT_W out of range");
    end
    if (PWRDN_CYCLES < 2 || PWRDN_CYCLES >= CNT_LIM ||
        LOCK_TIMEOUT < 1 || LOCK_TIMEOUT >= CNT_LIM ||
        LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES >= CNT_LIM) begin : g_bad_cycles
        $error("cycle parameter does not fit CNT_W or is below its minimum");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > 255) begin : g_bad_retries
        $error("MAX_RETRIES must be 1..255");
    end

    logic                w_lock_s;
    logic                w_lock_loss;
    logic                w_retry_inc;
    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [RETRY_W-1:0]  r_retry;
    logic [LOSS_W-1:0]   r_loss;
    logic                r_pwrdn_n;
    logic                r_fab_rst_n;
    logic                r_ready;
    logic                r_fault;

    sync_2ff u_lock_sync (
        .i_clk (REF_CLK_0),
        .i_rst (RESET_0),
        .i_d   (bus.PLL_LOCK_0),
        .o_q   (w_lock_s)
    );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = $clog2(GLITCH_FILTER_LEN);
    logic [FILT_W-1:0] r_filt;

    // Counts consecutive low lock_s cycles in RUN; the event fires on the last one.
    always_ff @(posedge REF_CLK_0) begin
        if (RESET_0 || r_state != ST_RUN || w_lock_s) begin
            r_filt <= '0;
        end else if (r_filt != FILT_W'(GLITCH_FILTER_LEN - 1)) begin
            r_filt <= r_filt + FILT_W'(1);
        end
    end

    assign w_lock_loss = (r_state == ST_RUN) && !w_lock_s &&
                         (r_filt == FILT_W'(GLITCH_FILTER_LEN - 1));
`else
    assign w_lock_loss = (r_state == ST_RUN) && !w_lock_s;
`endif

    always_comb begin
        w_next      = r_state;
        w_retry_inc = 1'b0;
        if (!bus.ENABLE) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_PWRDN;
                ST_PWRDN: begin
                    if (r_cnt == CNT_W'(PWRDN_CYCLES - 1)) w_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_next = ST_STABLE;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        w_retry_inc = 1'b1;
                        w_next = (r_retry + RETRY_W'(1) == RETRY_W'(MAX_RETRIES)) ?
                                 ST_FAULT : ST_PWRDN;
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s)                                   w_next = ST_WAIT_LOCK;
                    else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) w_next = ST_RUN;
                end
                ST_RUN: begin
                    if (w_lock_loss) w_next = ST_PWRDN;
                end
                ST_FAULT: w_next = ST_FAULT;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Counter restarts on every state change, so each timed state starts from zero.
    always_ff @(posedge REF_CLK_0) begin
        if (RESET_0) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pwrdn_n   <= 1'b0;
            r_fab_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == ST_IDLE || r_state == ST_RUN ||
                r_state == ST_FAULT) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == ST_IDLE && w_next == ST_PWRDN) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RETRY_W'(1);
            end
            if (bus.ENABLE && w_lock_loss && r_loss != '1) begin
                r_loss <= r_loss + LOSS_W'(1);
            end
            r_pwrdn_n   <= (w_next == ST_WAIT_LOCK) || (w_next == ST_STABLE) ||
                           (w_next == ST_RUN);
            r_fab_rst_n <= (w_next == ST_RUN);
            r_ready     <= (w_next == ST_RUN);
            r_fault     <= (w_next == ST_FAULT);
        end
    end

    assign bus.PLL_POWERDOWN_N_0 = r_pwrdn_n;
    assign bus.FAB_RESET_N       = r_fab_rst_n;
    assign bus.READY             = r_ready;
    assign bus.FAULT             = r_fault;
    assign bus.RETRY_CNT         = r_retry;
    assign bus.LOCK_LOSS_CNT     = r_loss;
    assign bus.STATE             = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed table-driven bench for pll_lock_sequencer (PWRDN=4, TIMEOUT=50, STABLE=8, RETRIES=2).
// Expectations for the RUN lock-loss segment follow PLL_LOCK_GLITCH_FILTER_EN.
module tb_pll_lock_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pll_lock_sequencer_if bus ();

    pll_lock_sequencer #(
        .PWRDN_CYCLES       (4),
        .LOCK_TIMEOUT       (50),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) dut (
        .REF_CLK_0 (clk),
        .RESET_0   (rst),
        .bus       (bus)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       lk;
        logic [2:0] st;
        logic       pd;
        logic       fab;
        logic       rdy;
        logic       flt;
        logic [7:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Appends n identical cycles: inputs held for the cycle, outputs expected after its edge.
    task automatic add(input int n, input logic r, input logic e, input logic l,
                       input logic [2:0] st, input logic pd, input logic fab,
                       input logic rdy, input logic flt, input logic [7:0] rc,
                       input logic [7:0] lc);
        vec_t v;
        v.rst = r; v.en = e; v.lk = l; v.st = st; v.pd = pd; v.fab = fab;
        v.rdy = rdy; v.flt = flt; v.rc = rc; v.lc = lc;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [22:0] exp);
        logic [22:0] act;
        act = {bus.STATE, bus.PLL_POWERDOWN_N_0, bus.FAB_RESET_N, bus.READY,
               bus.FAULT, bus.RETRY_CNT, bus.LOCK_LOSS_CNT};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%0d pd=%b fab=%b rdy=%b flt=%b rc=%0d lc=%0d, want st=%0d pd=%b fab=%b rdy=%b flt=%b rc=%0d lc=%0d",
                     name, act[22:20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                     exp[22:20], exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l);
        rst = r;
        bus.ENABLE = e;
        bus.PLL_LOCK_0 = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ENABLE = 1'b0;
        bus.PLL_LOCK_0 = 1'b0;

        // Reset, then nominal bring-up: 4 PWRDN cycles, lock applied 11 cycles into
        // WAIT_LOCK, READY after 2 sync + 1 transition + 8 stable cycles.
        add(2,  1,0,0, 3'd0, 0,0,0,0, 0,0);
        add(4,  0,1,0, 3'd1, 0,0,0,0, 0,0);
        add(11, 0,1,0, 3'd2, 1,0,0,0, 0,0);
        add(2,  0,1,1, 3'd2, 1,0,0,0, 0,0);
        add(8,  0,1,1, 3'd3, 1,0,0,0, 0,0);
        add(4,  0,1,1, 3'd4, 1,1,1,0, 0,0);
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        // 2-cycle drop ignored; 4-cycle drop recorded.
        add(2,  0,1,0, 3'd4, 1,1,1,0, 0,0);
        add(2,  0,1,1, 3'd4, 1,1,1,0, 0,0);
        add(4,  0,1,0, 3'd4, 1,1,1,0, 0,0);
        add(1,  0,1,1, 3'd4, 1,1,1,0, 0,0);
        add(4,  0,1,1, 3'd1, 0,0,0,0, 0,1);
        add(1,  0,1,1, 3'd2, 1,0,0,0, 0,1);
        add(8,  0,1,1, 3'd3, 1,0,0,0, 0,1);
        add(2,  0,1,1, 3'd4, 1,1,1,0, 0,1);
`else
        // 2-cycle drop is a loss: back through a full 4-cycle PWRDN.
        add(2,  0,1,0, 3'd4, 1,1,1,0, 0,0);
        add(4,  0,1,1, 3'd1, 0,0,0,0, 0,1);
        add(1,  0,1,1, 3'd2, 1,0,0,0, 0,1);
        add(8,  0,1,1, 3'd3, 1,0,0,0, 0,1);
        add(2,  0,1,1, 3'd4, 1,1,1,0, 0,1);
`endif
        // Stability glitch after 5 STABLE cycles: WAIT_LOCK, then 8 fresh clean cycles.
        add(1,  0,0,0, 3'd0, 0,0,0,0, 0,1);
        add(4,  0,1,0, 3'd1, 0,0,0,0, 0,1);
        add(2,  0,1,1, 3'd2, 1,0,0,0, 0,1);
        add(3,  0,1,1, 3'd3, 1,0,0,0, 0,1);
        add(1,  0,1,0, 3'd3, 1,0,0,0, 0,1);
        add(1,  0,1,1, 3'd3, 1,0,0,0, 0,1);
        add(1,  0,1,1, 3'd2, 1,0,0,0, 0,1);
        add(8,  0,1,1, 3'd3, 1,0,0,0, 0,1);
        add(1,  0,1,1, 3'd4, 1,1,1,0, 0,1);
        // Two 50-cycle timeouts -> FAULT; ENABLE=0 clears FAULT, RETRY_CNT held in IDLE.
        add(1,  0,0,0, 3'd0, 0,0,0,0, 0,1);
        add(4,  0,1,0, 3'd1, 0,0,0,0, 0,1);
        add(50, 0,1,0, 3'd2, 1,0,0,0, 0,1);
        add(4,  0,1,0, 3'd1, 0,0,0,0, 1,1);
        add(50, 0,1,0, 3'd2, 1,0,0,0, 1,1);
        add(3,  0,1,0, 3'd5, 0,0,0,1, 2,1);
        add(1,  0,0,0, 3'd0, 0,0,0,0, 2,1);
        // New session clears RETRY_CNT; ENABLE=0 on the timeout cycle wins.
        add(4,  0,1,0, 3'd1, 0,0,0,0, 0,1);
        add(49, 0,1,0, 3'd2, 1,0,0,0, 0,1);
        add(1,  0,0,0, 3'd0, 0,0,0,0, 0,1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].lk);
            check($sformatf("vec%0d", i),
                  {tbl[i].st, tbl[i].pd, tbl[i].fab, tbl[i].rdy, tbl[i].flt,
                   tbl[i].rc, tbl[i].lc});
        end

        // RESET_0 pulsed in RUN clears everything, including LOCK_LOSS_CNT.
        begin
            int budget;
            budget = 0;
            step(1'b0, 1'b1, 1'b1);
            while (bus.READY !== 1'b1 && budget < 100) begin
                step(1'b0, 1'b1, 1'b1);
                budget++;
            end
            check("reach_run", {3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1});
            step(1'b1, 1'b1, 1'b1);
            check("reset_in_run", {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
            step(1'b0, 1'b1, 1'b1);
            check("restart_after_reset", {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
